if_fetch_stage: RTL and testbench

- Fetch-side responder to the hazard detection unit's PCWrite/IFIDWrite/flush controls. Owns the PC register, the instruction-memory fetch handshake, a one-entry hold buffer and the IF/ID pipeline register.
- Sits between instruction memory and the ID stage.
- Turns stall, flush and redirect (branch/jump target) requests into cycle-exact PC and IF/ID updates.

---
 rtl/if_fetch_stage_pkg.sv | 28 ++
 rtl/if_fetch_stage_if.sv | 24 ++
 rtl/if_fetch_stage_ifid_reg.sv | 41 ++++
 rtl/if_fetch_stage.sv | 127 ++++++++++++
 tb/tb_if_fetch_stage.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared constants, types and helpers for the fetch stage
package if_fetch_stage_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t RESET_PC = 32'h0000_3000;
  localparam word_t NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_HOLD,
    ST_DROP
  } fetch_state_e;

  typedef enum logic [1:0] {
    IFID_HOLD,
    IFID_LOAD,
    IFID_BUBBLE
  } ifid_sel_e;

  function automatic word_t next_word_addr(input word_t addr);
    return addr + word_t'(4);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction-memory fetch handshake bundle
interface if_fetch_stage_if;
  import if_fetch_stage_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ready;
  word_t imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_stage_ifid_reg.sv
// rtl/if_fetch_stage_ifid_reg.sv - IF/ID pipeline register with load/hold/bubble select
module if_fetch_stage_ifid_reg
  import if_fetch_stage_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  ifid_sel_e sel,
  input  word_t     load_pc,
  input  word_t     load_inst,
  output logic      valid,
  output word_t     inst,
  output word_t     pc,
  output word_t     pc_plus4
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      inst     <= NOP_INST;
      pc       <= '0;
      pc_plus4 <= word_t'(4);
    end else begin
      case (sel)
        IFID_LOAD: begin
          valid    <= 1'b1;
          inst     <= load_inst;
          pc       <= load_pc;
          pc_plus4 <= next_word_addr(load_pc);
        end
        // A bubble keeps the old PC pair so later stages still see a sane address.
        IFID_BUBBLE: begin
          valid <= 1'b0;
          inst  <= NOP_INST;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - PC register, fetch FSM and hold buffer feeding the IF/ID register
module if_fetch_stage
  import if_fetch_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pc_write,
  input  logic                   ifid_write,
  input  logic                   flush,
  input  logic                   redirect_valid,
  input  word_t                  redirect_target,
  if_fetch_stage_if.master       imem,
  output logic                   id_valid,
  output word_t                  id_inst,
  output word_t                  id_pc,
  output word_t                  id_pc_plus4
);

  fetch_state_e state, state_n;
  word_t        pc, pc_n;
  word_t        hold_buf, hold_buf_n;
  word_t        pending, pending_n;
  logic         consume;
  logic         take_word;
  word_t        take_inst;
  ifid_sel_e    ifid_sel;

  assign consume        = pc_write & ifid_write & ~flush & ~redirect_valid;
  assign imem.imem_addr = pc;
  assign imem.imem_req  = (state == ST_FETCH) || (state == ST_DROP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_BOOT;
      pc       <= RESET_PC;
      hold_buf <= NOP_INST;
      pending  <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      hold_buf <= hold_buf_n;
      pending  <= pending_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    hold_buf_n = hold_buf;
    pending_n  = pending;
    take_word  = 1'b0;
    take_inst  = hold_buf;
    case (state)
      ST_BOOT: begin
        state_n = ST_FETCH;
      end
      ST_FETCH: begin
        take_inst = imem.imem_rdata;
        if (redirect_valid) begin
          // An unfinished fetch keeps its address until the memory answers; the word is then dropped.
          if (imem.imem_ready) begin
            pc_n = redirect_target;
          end else begin
            pending_n = redirect_target;
            state_n   = ST_DROP;
          end
        end else if (imem.imem_ready) begin
          if (consume) begin
            take_word = 1'b1;
            pc_n      = next_word_addr(pc);
          end else if (!flush) begin
            hold_buf_n = imem.imem_rdata;
            state_n    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_n    = redirect_target;
          state_n = ST_FETCH;
        end else if (flush) begin
          state_n = ST_FETCH;
        end else if (consume) begin
          take_word = 1'b1;
          pc_n      = next_word_addr(pc);
          state_n   = ST_FETCH;
        end
      end
      ST_DROP: begin
        if (redirect_valid) begin
          pending_n = redirect_target;
        end
        if (imem.imem_ready) begin
          pc_n    = redirect_valid ? redirect_target : pending;
          state_n = ST_FETCH;
        end
      end
      default: begin
        state_n = ST_BOOT;
      end
    endcase
  end

  always_comb begin
    ifid_sel = IFID_BUBBLE;
    if (flush) begin
      ifid_sel = IFID_BUBBLE;
    end else if (!ifid_write) begin
      ifid_sel = IFID_HOLD;
    end else if (take_word) begin
      ifid_sel = IFID_LOAD;
    end
  end

  if_fetch_stage_ifid_reg u_ifid_reg (
    .clk       (clk),
    .rst       (rst),
    .sel       (ifid_sel),
    .load_pc   (pc),
    .load_inst (take_inst),
    .valid     (id_valid),
    .inst      (id_inst),
    .pc        (id_pc),
    .pc_plus4  (id_pc_plus4)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench for the fetch stage
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_write = 1'b1;
  logic        ifid_write = 1'b1;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        id_valid;
  logic [31:0] id_inst, id_pc, id_pc_plus4;

  int checks = 0;
  int errors = 0;
  int lat = 0;
  int wait_cnt = 0;

  // reference model: where the fetcher is and what IF/ID should hold
  logic        m_started, m_buf_valid, m_dropping;
  logic [31:0] m_pc, m_buf, m_pending;
  logic        m_valid;
  logic [31:0] m_inst, m_idpc, m_idpc4;

  if_fetch_stage_if bus ();

  if_fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem            (bus),
    .id_valid        (id_valid),
    .id_inst         (id_inst),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic model_reset();
    m_started = 1'b0; m_buf_valid = 1'b0; m_dropping = 1'b0;
    m_pc = 32'h0000_3000; m_buf = '0; m_pending = '0;
    m_valid = 1'b0; m_inst = 32'h0; m_idpc = 32'h0; m_idpc4 = 32'h4;
  endtask

  task automatic model_step(input logic rdy);
    logic        cons, got;
    logic [31:0] word, n_pc;
    if (rst) begin
      model_reset();
      return;
    end
    cons = pc_write && ifid_write && !flush && !redirect_valid;
    got  = 1'b0;
    word = 32'h0;
    n_pc = m_pc;
    if (!m_started) begin
      m_started = 1'b1;
    end else if (m_buf_valid) begin
      if (redirect_valid) begin m_buf_valid = 1'b0; n_pc = redirect_target; end
      else if (flush) m_buf_valid = 1'b0;
      else if (cons) begin got = 1'b1; word = m_buf; m_buf_valid = 1'b0; n_pc = m_pc + 32'd4; end
    end else if (m_dropping) begin
      if (redirect_valid) m_pending = redirect_target;
      if (rdy) begin m_dropping = 1'b0; n_pc = m_pending; end
    end else begin
      if (redirect_valid) begin
        if (rdy) n_pc = redirect_target;
        else begin m_dropping = 1'b1; m_pending = redirect_target; end
      end else if (rdy) begin
        if (cons) begin got = 1'b1; word = word_of(m_pc); n_pc = m_pc + 32'd4; end
        else if (!flush) begin m_buf_valid = 1'b1; m_buf = word_of(m_pc); end
      end
    end
    if (flush) begin
      m_valid = 1'b0; m_inst = 32'h0;
    end else if (!ifid_write) begin
      m_valid = m_valid;
    end else if (got) begin
      m_valid = 1'b1; m_inst = word; m_idpc = m_pc; m_idpc4 = m_pc + 32'd4;
    end else begin
      m_valid = 1'b0; m_inst = 32'h0;
    end
    m_pc = n_pc;
  endtask

  // memory answers the DUT's request after 'lat' wait cycles; the model advances alongside
  task automatic step();
    logic req_s, rdy_s;
    req_s = bus.imem_req;
    rdy_s = req_s && (wait_cnt >= lat);
    bus.imem_ready = rdy_s;
    bus.imem_rdata = rdy_s ? word_of(bus.imem_addr) : 32'hDEAD_BEEF;
    model_step(rdy_s);
    @(posedge clk);
    if (rst || !req_s || rdy_s) wait_cnt = 0;
    else wait_cnt++;
    #1;
  endtask

  task automatic set_idle();
    pc_write = 1'b1; ifid_write = 1'b1; flush = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", id_valid); end
    checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 00000000", id_inst); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 00000000", id_pc); end
    checks++; if (id_pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc4 got %h want 00000004", id_pc_plus4); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h3000) begin errors++; $display("FAIL reset_addr got %h want 00003000", bus.imem_addr); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h3000, 32'h3004, 32'h3008};
    lat = 0;
    set_idle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.imem_req !== (i != 0)) begin errors++; $display("FAIL zw_req[%0d] got %0b want %0b", i, bus.imem_req, i != 0); end
      step();
      checks++;
      if (id_valid !== (i != 0)) begin errors++; $display("FAIL zw_valid[%0d] got %0b want %0b", i, id_valid, i != 0); end
      if (i != 0) begin
        checks++;
        if (id_pc !== exp_pc[i] || id_inst !== word_of(exp_pc[i]) || id_pc_plus4 !== exp_pc[i] + 32'd4) begin
          errors++; $display("FAIL zw_ifid[%0d] got pc=%h inst=%h pc4=%h want pc=%h", i, id_pc, id_inst, id_pc_plus4, exp_pc[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc   [4] = '{32'h3008, 32'h3008, 32'h300C, 32'h3010};
    logic        exp_req  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] exp_addr [4] = '{32'h300C, 32'h3010, 32'h3010, 32'h3010};
    for (int i = 0; i < 4; i++) begin
      pc_write = (i >= 2); ifid_write = (i >= 2);
      checks++;
      if (bus.imem_req !== exp_req[i]) begin errors++; $display("FAIL stall_req[%0d] got %0b want %0b", i, bus.imem_req, exp_req[i]); end
      if (exp_req[i] && i != 1) begin
        checks++;
        if (bus.imem_addr !== exp_addr[i]) begin errors++; $display("FAIL stall_addr[%0d] got %h want %h", i, bus.imem_addr, exp_addr[i]); end
      end
      step();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== exp_pc[i] || id_inst !== word_of(exp_pc[i])) begin
        errors++; $display("FAIL stall_ifid[%0d] got v=%0b pc=%h inst=%h want pc=%h", i, id_valid, id_pc, id_inst, exp_pc[i]);
      end
    end
    set_idle();
  endtask

  task automatic test_flush_redirect();
    checks++;
    if (bus.imem_addr !== 32'h3014) begin errors++; $display("FAIL fr_addr got %h want 00003014", bus.imem_addr); end
    flush = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h4000;
    step();
    set_idle();
    checks++;
    if (id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc !== 32'h3010) begin
      errors++; $display("FAIL fr_bubble got v=%0b inst=%h pc=%h want v=0 inst=00000000 pc=00003010", id_valid, id_inst, id_pc);
    end
    checks++;
    if (bus.imem_addr !== 32'h4000) begin errors++; $display("FAIL fr_newaddr got %h want 00004000", bus.imem_addr); end
    step();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h4000) begin errors++; $display("FAIL fr_target got v=%0b pc=%h want v=1 pc=00004000", id_valid, id_pc); end
  endtask

  // 'second' selects the double-redirect variant: a later redirect in DROP wins
  task automatic drop_sequence(input logic second, input logic [31:0] old_pc, input logic [31:0] final_pc);
    logic [31:0] exp_addr;
    lat = 2;
    for (int i = 0; i < 6; i++) begin
      set_idle();
      if (i == 0) begin redirect_valid = 1'b1; redirect_target = 32'h5000; end
      if (i == 1 && second) begin redirect_valid = 1'b1; redirect_target = 32'h6000; end
      exp_addr = (i < 3) ? old_pc : final_pc;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_addr) begin
        errors++; $display("FAIL drop%0d_addr[%0d] got req=%0b addr=%h want req=1 addr=%h", second, i, bus.imem_req, bus.imem_addr, exp_addr);
      end
      step();
      checks++;
      if (i < 5 && id_valid !== 1'b0) begin errors++; $display("FAIL drop%0d_valid[%0d] got %0b want 0", second, i, id_valid); end
      if (i == 5 && (id_valid !== 1'b1 || id_pc !== final_pc || id_inst !== word_of(final_pc))) begin
        errors++; $display("FAIL drop%0d_ifid got v=%0b pc=%h inst=%h want pc=%h", second, id_valid, id_pc, id_inst, final_pc);
      end
    end
    set_idle();
  endtask

  task automatic test_latency_drop();
    drop_sequence(1'b0, 32'h4004, 32'h5000);
  endtask

  task automatic test_double_redirect();
    drop_sequence(1'b1, 32'h5004, 32'h6000);
  endtask

  task automatic test_wrap_reset();
    lat = 0;
    set_idle();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    set_idle();
    checks++;
    if (id_valid !== 1'b0) begin errors++; $display("FAIL wrap_bubble got %0b want 0", id_valid); end
    step();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0) begin
      errors++; $display("FAIL wrap_top got v=%0b pc=%h pc4=%h want pc=fffffffc pc4=00000000", id_valid, id_pc, id_pc_plus4);
    end
    step();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h4) begin
      errors++; $display("FAIL wrap_zero got v=%0b pc=%h pc4=%h want pc=00000000 pc4=00000004", id_valid, id_pc, id_pc_plus4);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || bus.imem_addr !== 32'h3000 || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL wrap_rst got v=%0b addr=%h req=%0b want v=0 addr=00003000 req=0", id_valid, bus.imem_addr, bus.imem_req);
    end
  endtask

  task automatic test_random();
    set_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) lat = $urandom_range(0, 3);
      rst            = ($urandom_range(0, 199) == 0);
      pc_write       = ($urandom_range(0, 9) != 0);
      ifid_write     = ($urandom_range(0, 9) != 0);
      flush          = ($urandom_range(0, 11) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      checks++;
      if (bus.imem_req !== (m_started && !m_buf_valid) || bus.imem_addr !== m_pc) begin
        errors++; $display("FAIL rnd_bus[%0d] got req=%0b addr=%h want req=%0b addr=%h", i, bus.imem_req, bus.imem_addr, m_started && !m_buf_valid, m_pc);
      end
      step();
      checks++;
      if (id_valid !== m_valid || id_inst !== m_inst || id_pc !== m_idpc || id_pc_plus4 !== m_idpc4) begin
        errors++; $display("FAIL rnd_ifid[%0d] got v=%0b inst=%h pc=%h pc4=%h want v=%0b inst=%h pc=%h pc4=%h",
                           i, id_valid, id_inst, id_pc, id_pc_plus4, m_valid, m_inst, m_idpc, m_idpc4);
      end
    end
    rst = 1'b0;
    set_idle();
  endtask

  initial begin
    bus.imem_ready = 1'b0;
    bus.imem_rdata = '0;
    model_reset();
    test_reset();
    test_zero_wait();
    test_stall();
    test_flush_redirect();
    test_latency_drop();
    test_double_redirect();
    test_wrap_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
